// File: rtl/divider_arbiter_pkg.sv
// Shared definitions for the divider arbiter: FSM state encoding, saturated
// result constant and requester IDs.
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    localparam logic [31:0] RESULT_SAT = 32'hFFFF_FFFF;

    localparam logic REQ_FREQ = 1'b0;
    localparam logic REQ_PER  = 1'b1;

endpackage

// File: rtl/divider_arbiter_if.sv
// Requester and divider handshake bundle. The arbiter uses the master view;
// requesters and the divider together see the slave view.
interface divider_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              freq_req;
    logic [DATA_W-1:0] freq_period;
    logic              freq_ack;
    logic [DATA_W-1:0] freq_result;
    logic              freq_valid;

    logic              per_req;
    logic [DATA_W-1:0] per_period;
    logic              per_ack;
    logic [DATA_W-1:0] per_result;
    logic              per_valid;

    logic              div_start;
    logic [DATA_W-1:0] div_numerator;
    logic [DATA_W-1:0] div_divisor;
    logic [DATA_W-1:0] div_quotient;
    logic              div_done;

    modport master (
        input  freq_req, freq_period, per_req, per_period, div_quotient, div_done,
        output freq_ack, freq_result, freq_valid, per_ack, per_result, per_valid,
               div_start, div_numerator, div_divisor
    );

    modport slave (
        output freq_req, freq_period, per_req, per_period, div_quotient, div_done,
        input  freq_ack, freq_result, freq_valid, per_ack, per_result, per_valid,
               div_start, div_numerator, div_divisor
    );

endinterface

// File: rtl/divider_arbiter_rr.sv
// Two-input round-robin grant: combinational choice, last-grant pointer
// updated when a transaction is delivered.
module rr_arbiter_2
    import div_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served_id,
    output logic       grant_id,
    output logic       grant_any
);

    logic last_reg;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_any = |req;
        if (req == 2'b11) begin
            grant_id = ~last_reg;
        end else if (req[REQ_FREQ]) begin
            grant_id = REQ_FREQ;
        end else begin
            grant_id = REQ_PER;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            last_reg <= REQ_PER;
        end else if (update) begin
            last_reg <= served_id;
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Time-shares one iterative divider between a frequency and a period requester.
// Optional per-requester delivery counters: define DIV_ARB_STATS_EN.
module divider_arbiter
    import div_arb_pkg::*;
#(
    parameter int          DATA_W         = 32,
    parameter int unsigned FREQ_NUM       = 5000,
    parameter int unsigned PER_DIV        = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    divider_arbiter_if.master bus,
    output logic              busy,
    output logic              timeout_err
`ifdef DIV_ARB_STATS_EN
    ,
    output logic [15:0]       freq_grants,
    output logic [15:0]       per_grants
`endif
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_W-1:0] SAT_VAL =
        DATA_W'({((DATA_W + 31) / 32){RESULT_SAT}});

    state_t            state_reg;
    logic              winner_reg;
    logic [DATA_W-1:0] num_reg;
    logic [DATA_W-1:0] div_reg;
    logic [DATA_W-1:0] pending_reg;
    logic [DATA_W-1:0] res_reg [2];
    logic [1:0]        ack_reg;
    logic [1:0]        valid_reg;
    logic              start_reg;
    logic              timeout_reg;
    logic [WD_W-1:0]   wd_reg;

    logic [1:0]        req_vec;
    logic              grant_id;
    logic              grant_any;
    logic              deliver;
    logic [DATA_W-1:0] grant_num;
    logic [DATA_W-1:0] grant_div;

    assign deliver = (state_reg == DELIVER);

    always_comb begin
        req_vec[REQ_FREQ] = bus.freq_req;
        req_vec[REQ_PER]  = bus.per_req;
        if (grant_id == REQ_FREQ) begin
            grant_num = DATA_W'(FREQ_NUM);
            grant_div = bus.freq_period;
        end else begin
            grant_num = bus.per_period;
            grant_div = DATA_W'(PER_DIV);
        end
    end

    rr_arbiter_2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_vec),
        .update    (deliver),
        .served_id (winner_reg),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg   <= IDLE;
            winner_reg  <= REQ_FREQ;
            num_reg     <= '0;
            div_reg     <= '0;
            pending_reg <= '0;
            res_reg[0]  <= '0;
            res_reg[1]  <= '0;
            ack_reg     <= '0;
            valid_reg   <= '0;
            start_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            wd_reg      <= '0;
        end else begin
            ack_reg   <= '0;
            valid_reg <= '0;
            start_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        winner_reg        <= grant_id;
                        num_reg           <= grant_num;
                        div_reg           <= grant_div;
                        ack_reg[grant_id] <= 1'b1;
                        // A zero divisor never reaches the divider.
                        if (grant_div == '0) begin
                            pending_reg <= SAT_VAL;
                            state_reg   <= DELIVER;
                        end else begin
                            start_reg <= 1'b1;
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wd_reg    <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (bus.div_done) begin
                        pending_reg <= bus.div_quotient;
                        state_reg   <= DELIVER;
                    end else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        pending_reg <= SAT_VAL;
                        timeout_reg <= 1'b1;
                        state_reg   <= DELIVER;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                DELIVER: begin
                    // Result and valid update together so a consumer never
                    // sees a new value without its strobe.
                    res_reg[winner_reg]   <= pending_reg;
                    valid_reg[winner_reg] <= 1'b1;
                    state_reg             <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy            = (state_reg != IDLE);
    assign timeout_err     = timeout_reg;
    assign bus.freq_ack    = ack_reg[REQ_FREQ];
    assign bus.per_ack     = ack_reg[REQ_PER];
    assign bus.freq_valid  = valid_reg[REQ_FREQ];
    assign bus.per_valid   = valid_reg[REQ_PER];
    assign bus.freq_result = res_reg[REQ_FREQ];
    assign bus.per_result  = res_reg[REQ_PER];
    assign bus.div_start     = start_reg;
    assign bus.div_numerator = num_reg;
    assign bus.div_divisor   = div_reg;

`ifdef DIV_ARB_STATS_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_stats
        logic [15:0] cnt_reg;
        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                cnt_reg <= '0;
            end else if (deliver && winner_reg == 1'(gi) && cnt_reg != 16'hFFFF) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end
    assign freq_grants = g_stats[0].cnt_reg;
    assign per_grants  = g_stats[1].cnt_reg;
`endif

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Time-shares one iterative 32-bit divider between two requesters:
  - frequency path: computes FREQ_NUM / period;
  - period path: computes period / PER_DIV.
- Sits between the measurement front end and the BCD conversion/rounding stages.
- Sequences one divide at a time with round-robin fairness, a divide-by-zero bypass and a watchdog, and returns each result with a one-cycle valid pulse.

Parameters:
- DATA_W, 32, operand and quotient width.
- FREQ_NUM, 5000, constant numerator for frequency requests.
- PER_DIV, 5000, constant divisor for period requests.
- TIMEOUT_CYCLES, 64, maximum cycles allowed between div_start and div_done.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-high: rst_n=1 resets.
- freq_req  in  1  frequency divide request. Held high until freq_ack.
- freq_period  in  DATA_W  measured period for the frequency request.
- freq_ack  out  1  one-cycle pulse: request accepted, operand latched.
- freq_result  out  DATA_W  last frequency quotient. Held between updates.
- freq_valid  out  1  one-cycle pulse when freq_result updates.
- per_req / per_period / per_ack / per_result / per_valid: same set of signals for the period requester.
- div_start  out  1  one-cycle start pulse to the divider.
- div_numerator  out  DATA_W  registered numerator.
- div_divisor  out  DATA_W  registered divisor.
- div_quotient  in  DATA_W  divider quotient.
- div_done  in  1  divider completion pulse.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky flag. Set on watchdog expiry; cleared only by reset.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, last-grant pointer = period (so freq wins first).
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - On an edge where any req is high, pick a winner:
    - if one requester is high, it wins;
    - if both are high, the one not granted last wins.
  - Latch operands:
    - freq: numerator = FREQ_NUM, divisor = freq_period;
    - per: numerator = per_period, divisor = PER_DIV.
  - Assert the winner's ack for exactly the next cycle.
  - Go to ISSUE, or go directly to DELIVER with result 32'hFFFF_FFFF if the latched divisor is 0.
- ISSUE: div_start=1 for one cycle; clear watchdog; go to WAIT.
- WAIT:
  - On an edge with div_done=1, capture div_quotient into the winner's result register and go to DELIVER.
  - Watchdog increments each cycle. On reaching TIMEOUT_CYCLES: result = all-ones, timeout_err set, go to DELIVER.
- DELIVER: winner's valid=1 for one cycle; update last-grant pointer; return to IDLE.
- Latency: req edge to valid = 3 cycles + divider latency (cycles from div_start to div_done). Zero-divisor bypass: 2 cycles.
- A request held through its own ack is not re-granted. The requester must drop req within the ack cycle, or it is treated as a new request.
- div_done outside WAIT is ignored, including stale completions after reset.
- Result registers of the non-winning requester never change.
- Reset mid-operation: abort immediately; div_start low; the pending divide result is discarded.
- Operand registers hold while not in IDLE, so requester input changes have no effect.

Optional Feature:
- Macro: DIV_ARB_STATS_EN.
- With the macro defined:
  - adds outputs freq_grants and per_grants, each 16 bits;
  - each is a saturating count of completed DELIVERs per requester (stops at 16'hFFFF);
  - both counters are zeroed by reset.
- Without the macro: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package div_arb_pkg holds:
  - FSM state encodings (IDLE=0, ISSUE=1, WAIT=2, DELIVER=3);
  - the RESULT_SAT all-ones constant;
  - requester ID constants REQ_FREQ=0 and REQ_PER=1.
- Sub-module rr_arbiter_2: two-input round-robin grant with a last-grant register. Combinational grant, registered pointer update on DELIVER.

Test Plan:
- freq_req with freq_period=1000 and a divider returning 5 after 10 cycles → freq_ack at cycle 1, div_numerator=5000, div_divisor=1000, freq_valid at cycle 13 with freq_result=5.
- freq_req and per_req both high from reset → freq served first, then per. A second simultaneous pair is served per first, then freq (alternation).
- freq_period=0 → no div_start; freq_valid 2 cycles after req with freq_result=32'hFFFF_FFFF.
- Divider never asserts div_done → after 64 cycles in WAIT, result all-ones, timeout_err=1 and stays 1; the next request completes normally.
- Reset mid-WAIT, then a late div_done pulse → outputs zero, no valid pulse, FSM stays IDLE.
- DIV_ARB_STATS_EN defined, 3 freq and 2 per requests → freq_grants=3, per_grants=2. Preload near saturation → count holds at 16'hFFFF.
